// File: rtl/pifo_pkg.sv
// +--------------------------------------------------------------------------+
// | pifo_pkg : shared rank field location and entry layout for the PIFO      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package pifo_pkg;

  localparam int RANK_LSB   = 32;
  localparam int RANK_WIDTH = 16;

  localparam int PIFO_DATA_WIDTH = 256;
  localparam int PIFO_KEEP_WIDTH = PIFO_DATA_WIDTH / 8;
  localparam int PIFO_USER_WIDTH = 168;

  typedef logic [RANK_WIDTH-1:0] rank_t;

  typedef struct packed {
    logic [PIFO_DATA_WIDTH-1:0] data;
    logic [PIFO_KEEP_WIDTH-1:0] keep;
    logic [PIFO_USER_WIDTH-1:0] user;
    rank_t                      rank;
  } pifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/pifo_block.sv
// +--------------------------------------------------------------------------+
// | pifo_block : one sorted storage slot; keeps, loads or shifts an entry    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pifo_block
  import pifo_pkg::*;
#(
  parameter bit IS_HEAD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  pifo_entry_t new_entry,
  input  pifo_entry_t prev_entry,
  input  logic        prev_valid,
  input  logic        prev_after,
  input  pifo_entry_t next_entry,
  input  logic        next_valid,
  input  logic        next_after,
  output pifo_entry_t entry,
  output logic        valid,
  output logic        after
);

  pifo_entry_t entry_q, entry_d;
  logic        valid_q, valid_d;

  // The incoming element belongs behind this slot (ties keep arrival order).
  assign after = valid_q && (entry_q.rank <= new_entry.rank);
  assign entry = entry_q;
  assign valid = valid_q;

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    case ({push, pop})
      2'b10: begin
        if (!after) begin
          if (IS_HEAD || prev_after) begin
            entry_d = new_entry;
            valid_d = 1'b1;
          end else begin
            entry_d = prev_entry;
            valid_d = prev_valid;
          end
        end
      end
      2'b01: begin
        entry_d = next_entry;
        valid_d = next_valid;
      end
      2'b11: begin
        // Queue slides toward the head; the new element lands among survivors.
        if (next_after) begin
          entry_d = next_entry;
          valid_d = next_valid;
        end else if (IS_HEAD || after) begin
          entry_d = new_entry;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pifo_axis_module.sv
// +--------------------------------------------------------------------------+
// | pifo_axis_module : AXI-Stream PIFO ordered by tuser rank, single-beat    |
// | elements. Define PIFO_OCCUPANCY_EN to expose the pifo_occupancy port.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pifo_axis_module
  import pifo_pkg::*;
#(
  parameter int   DATA_WIDTH      = 256,
  parameter int   SUME_META_WIDTH = 168,
  parameter int   NUM_PIFO_BLOCK  = 5,
  localparam int  KEEP_WIDTH      = DATA_WIDTH / 8,
  localparam int  COUNT_WIDTH     = $clog2(NUM_PIFO_BLOCK + 1)
) (
  input  logic                       clk_in_0,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]      s_axis_tkeep,
  input  logic [SUME_META_WIDTH-1:0] s_axis_tuser,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
  output logic [SUME_META_WIDTH-1:0] m_axis_tuser,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready
`ifdef PIFO_OCCUPANCY_EN
  ,
  output logic [COUNT_WIDTH-1:0]     pifo_occupancy
`endif
);

  // Entry layout lives in the shared package, so widths must agree with it.
  if (DATA_WIDTH != PIFO_DATA_WIDTH || SUME_META_WIDTH != PIFO_USER_WIDTH) begin : g_width_check
    $error("pifo_axis_module: widths must match pifo_pkg entry layout");
  end
  if (NUM_PIFO_BLOCK < 2 || NUM_PIFO_BLOCK > 64) begin : g_depth_check
    $error("pifo_axis_module: NUM_PIFO_BLOCK must be in 2..64");
  end

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   s_ready_q, s_ready_d;
  logic                   push, pop;
  pifo_entry_t            new_entry;
  pifo_entry_t            entry_w [NUM_PIFO_BLOCK];
  logic                   valid_w [NUM_PIFO_BLOCK];
  logic                   after_w [NUM_PIFO_BLOCK];

  // Single-beat packets: tlast carries no information on ingress.
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

  assign new_entry = '{data: s_axis_tdata,
                       keep: s_axis_tkeep,
                       user: s_axis_tuser,
                       rank: s_axis_tuser[RANK_LSB +: RANK_WIDTH]};

  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tlast  = m_axis_tvalid;
  assign m_axis_tdata  = entry_w[0].data;
  assign m_axis_tkeep  = entry_w[0].keep;
  assign m_axis_tuser  = entry_w[0].user;
  assign s_axis_tready = s_ready_q;

  assign push = s_axis_tvalid && s_ready_q;
  assign pop  = m_axis_tvalid && m_axis_tready;

`ifdef PIFO_OCCUPANCY_EN
  assign pifo_occupancy = count_q;
`endif

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
    s_ready_d = (count_d < COUNT_WIDTH'(NUM_PIFO_BLOCK));
  end

  always_ff @(posedge clk_in_0 or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
    end
  end

  for (genvar i = 0; i < NUM_PIFO_BLOCK; i++) begin : g_block
    pifo_entry_t prev_entry, next_entry;
    logic        prev_valid, prev_after, next_valid, next_after;

    if (i == 0) begin : g_head
      assign prev_entry = '0;
      assign prev_valid = 1'b0;
      assign prev_after = 1'b1;
    end else begin : g_link_prev
      assign prev_entry = entry_w[i-1];
      assign prev_valid = valid_w[i-1];
      assign prev_after = after_w[i-1];
    end

    if (i == NUM_PIFO_BLOCK - 1) begin : g_tail
      assign next_entry = '0;
      assign next_valid = 1'b0;
      assign next_after = 1'b0;
    end else begin : g_link_next
      assign next_entry = entry_w[i+1];
      assign next_valid = valid_w[i+1];
      assign next_after = after_w[i+1];
    end

    pifo_block #(
      .IS_HEAD (i == 0)
    ) u_block (
      .clk        (clk_in_0),
      .rst_n      (reset),
      .push       (push),
      .pop        (pop),
      .new_entry  (new_entry),
      .prev_entry (prev_entry),
      .prev_valid (prev_valid),
      .prev_after (prev_after),
      .next_entry (next_entry),
      .next_valid (next_valid),
      .next_after (next_after),
      .entry      (entry_w[i]),
      .valid      (valid_w[i]),
      .after      (after_w[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pifo_axis_module.sv
// +--------------------------------------------------------------------------+
// | tb_pifo_axis_module : directed and random stimulus against a PIFO model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pifo_axis_module;

  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 168;
  localparam int N  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic [UW-1:0] s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b1;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b0;
`ifdef PIFO_OCCUPANCY_EN
  logic [2:0]    occ;
`endif

  always #5 clk = ~clk;

  pifo_axis_module #(
    .DATA_WIDTH      (DW),
    .SUME_META_WIDTH (UW),
    .NUM_PIFO_BLOCK  (N)
  ) dut (
    .clk_in_0      (clk),
    .reset         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready)
`ifdef PIFO_OCCUPANCY_EN
    ,
    .pifo_occupancy (occ)
`endif
  );

  // Reference: unordered bag of elements; head = min (rank, arrival number).
  typedef struct {
    logic [15:0]   rank;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    int            seq;
  } elem_t;

  elem_t q[$];
  int    seq_ctr = 0;
  bit    ready_m = 1'b0;
  int    errors  = 0;
  int    checks  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int head_idx();
    int h = 0;
    for (int i = 1; i < q.size(); i++)
      if (q[i].rank < q[h].rank || (q[i].rank == q[h].rank && q[i].seq < q[h].seq))
        h = i;
    return h;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] rand_user(input logic [15:0] rank);
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
    r[32 +: 16] = rank;
    return r[UW-1:0];
  endfunction

  task automatic check_outputs(input string tag);
    int h;
    check({tag, ".tvalid"}, DW'(m_tvalid), DW'(q.size() != 0));
    check({tag, ".tready"}, DW'(s_tready), DW'(ready_m));
`ifdef PIFO_OCCUPANCY_EN
    check({tag, ".occ"}, DW'(occ), DW'(q.size()));
`endif
    if (!rst_n) check({tag, ".rst_data"}, m_tdata, '0);
    if (q.size() != 0) begin
      h = head_idx();
      check({tag, ".tlast"}, DW'(m_tlast), DW'(1));
      check({tag, ".tdata"}, m_tdata, q[h].data);
      check({tag, ".tkeep"}, DW'(m_tkeep), DW'(q[h].keep));
      check({tag, ".tuser"}, DW'(m_tuser), DW'(q[h].user));
    end
  endtask

  // Called at a falling edge: check, drive, cross one rising edge, update model.
  task automatic cycle(input bit iv, input logic [15:0] rank, input logic [DW-1:0] data,
                       input bit oready, input string tag);
    elem_t e;
    bit    push, pop;
    check_outputs(tag);
    s_tvalid = iv;
    s_tdata  = data;
    s_tkeep  = KW'($urandom);
    s_tuser  = rand_user(rank);
    m_tready = oready;
    push = iv && ready_m && rst_n;
    pop  = (q.size() != 0) && oready && rst_n;
    @(posedge clk);
    if (pop) q.delete(head_idx());
    if (push) begin
      e.rank = rank;
      e.data = data;
      e.keep = s_tkeep;
      e.user = s_tuser;
      e.seq  = seq_ctr++;
      q.push_back(e);
    end
    ready_m = rst_n && (q.size() < N);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'd1, rand_data(), 1'b1, "reset");
    rst_n = 1'b1;
    cycle(1'b0, 16'd0, '0, 1'b0, "release");

    // Sorting with the egress stalled.
    cycle(1'b1, 16'd30, rand_data(), 1'b0, "sort");
    cycle(1'b1, 16'd10, rand_data(), 1'b0, "sort");
    cycle(1'b1, 16'd20, rand_data(), 1'b0, "sort");
    check("sort_first", DW'(m_tuser[32 +: 16]), DW'(10));
    cycle(1'b0, 16'd0, '0, 1'b1, "sort_pop");
    check("sort_second", DW'(m_tuser[32 +: 16]), DW'(20));
    cycle(1'b0, 16'd0, '0, 1'b1, "sort_pop");
    check("sort_third", DW'(m_tuser[32 +: 16]), DW'(30));
    cycle(1'b0, 16'd0, '0, 1'b1, "sort_pop");

    // Equal ranks leave in arrival order.
    cycle(1'b1, 16'd7, DW'(32'hA), 1'b0, "tie");
    cycle(1'b1, 16'd7, DW'(32'hB), 1'b0, "tie");
    check("tie_first", m_tdata, DW'(32'hA));
    cycle(1'b0, 16'd0, '0, 1'b1, "tie_pop");
    check("tie_second", m_tdata, DW'(32'hB));
    cycle(1'b0, 16'd0, '0, 1'b1, "tie_pop");

    // Fill, hold a sixth beat, release it with one pop.
    for (int i = 0; i < N; i++) cycle(1'b1, 16'($urandom_range(0, 9)), rand_data(), 1'b0, "fill");
    check("full_ready", DW'(s_tready), DW'(0));
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'd99, DW'(32'h6), 1'b0, "held");
    cycle(1'b1, 16'd99, DW'(32'h6), 1'b1, "full_pop");
    check("ready_after_pop", DW'(s_tready), DW'(1));
    cycle(1'b1, 16'd99, DW'(32'h6), 1'b0, "sixth");
    for (int i = 0; i < N + 1; i++) cycle(1'b0, 16'd0, '0, 1'b1, "drain");

    // Push and pop in the same cycle.
    cycle(1'b1, 16'd3, rand_data(), 1'b0, "pp");
    cycle(1'b1, 16'd8, rand_data(), 1'b0, "pp");
    cycle(1'b1, 16'd5, rand_data(), 1'b1, "pp_both");
    check("pp_head", DW'(m_tuser[32 +: 16]), DW'(5));
    check("pp_ready", DW'(s_tready), DW'(1));
    cycle(1'b0, 16'd0, '0, 1'b1, "pp_pop");
    check("pp_tail", DW'(m_tuser[32 +: 16]), DW'(8));
    cycle(1'b0, 16'd0, '0, 1'b1, "pp_pop");

    // Asynchronous reset with four entries stored.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'($urandom_range(0, 9)), rand_data(), 1'b0, "prefill");
    s_tvalid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", DW'(m_tvalid), DW'(0));
    check("async_rst_tready", DW'(s_tready), DW'(0));
    check("async_rst_tdata", m_tdata, '0);
    q.delete();
    ready_m = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'd0, '0, 1'b1, "in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'd0, '0, 1'b1, "after_reset");

    // Random traffic with narrow ranks to exercise ties.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, 16'($urandom_range(0, 7)), rand_data(),
            $urandom_range(0, 2) != 0, "rand");
    for (int i = 0; i < N + 1; i++) cycle(1'b0, 16'd0, '0, 1'b1, "final_drain");
    check_outputs("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pifo_axis_module.md
PIFO_AXIS_MODULE -- requirements
Module: pifo_axis_module

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, tdata width in bits.
REQ-002 SHALL have parameter SUME_META_WIDTH, default 168, tuser width in bits.
REQ-003 SHALL have parameter NUM_PIFO_BLOCK, default 5, number of storage entries; legal range 2..64.
REQ-004 SHALL derive localparam KEEP_WIDTH = DATA_WIDTH/8.
REQ-005 SHALL have ports, as follows; one clock; reset is asynchronous and active-low:
- clk_in_0  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- s_axis_tdata/tkeep/tuser  in  DATA_WIDTH/KEEP_WIDTH/SUME_META_WIDTH  ingress beat.
- s_axis_tvalid/tlast  in  1  ingress valid/last.
- s_axis_tready  out  1  ingress ready.
- m_axis_tdata/tkeep/tuser  out  DATA_WIDTH/KEEP_WIDTH/SUME_META_WIDTH  egress beat.
- m_axis_tvalid/tlast  out  1  egress valid/last.
- m_axis_tready  in  1  egress ready.

Function
REQ-006 SHALL treat every accepted beat as one element; packets are single-beat; m_axis_tlast SHALL always be 1 when m_axis_tvalid=1.
REQ-007 SHALL take rank as unsigned s_axis_tuser[RANK_LSB +: RANK_WIDTH], RANK_LSB=32, RANK_WIDTH=16.
REQ-008 SHALL store tdata, tkeep, tuser and rank per entry, kept sorted ascending by rank; head = lowest rank.
REQ-009 SHALL break rank ties in arrival order (earlier first).
REQ-010 SHALL accept a push on the rising edge when s_axis_tvalid && s_axis_tready.
REQ-011 SHALL perform a pop on the rising edge when m_axis_tvalid && m_axis_tready.
REQ-012 SHALL drive s_axis_tready = (count < NUM_PIFO_BLOCK), registered from count; no full-bypass on simultaneous pop.
REQ-013 SHALL drive m_axis_tvalid = (count != 0); m_axis_tdata/tkeep/tuser from head entry; outputs stable while tvalid && !tready.
REQ-014 SHALL have one-cycle latency: an element pushed into an empty queue appears at the output the cycle after acceptance.
REQ-015 SHALL, on simultaneous push and pop, remove the old head and insert the new element among the remaining entries; count unchanged.
REQ-016 SHALL not interpret tdata/tkeep; values pass through unchanged.
REQ-017 SHALL keep count in clog2(NUM_PIFO_BLOCK+1) bits; never exceeds NUM_PIFO_BLOCK nor underflows.

Reset
REQ-018 SHALL, while reset=0, clear count, drive m_axis_tvalid=0, s_axis_tready=0, m_axis_tdata/tkeep/tuser=0.
REQ-019 SHALL drive s_axis_tready=1 on the first clock edge after reset deasserts.
REQ-020 SHALL discard all stored entries on reset asserted mid-operation; no partial output.

Configuration
REQ-021 SHALL, when macro PIFO_OCCUPANCY_EN is defined, add output pifo_occupancy [clog2(NUM_PIFO_BLOCK+1)-1:0] equal to count, reset 0.
REQ-022 SHALL, without PIFO_OCCUPANCY_EN, omit that port; all other behaviour identical.

Structure
REQ-023 SHALL place RANK_LSB, RANK_WIDTH and the entry struct typedef (data, keep, user, rank) in shared package pifo_pkg.
REQ-024 SHALL implement each entry as sub-module pifo_block (holds one entry, compares incoming rank, shifts from neighbour); NUM_PIFO_BLOCK instances.

Verification
REQ-025 Reset held low 10 cycles -> m_axis_tvalid=0, s_axis_tready=0; after release, s_axis_tready=1 next edge.
REQ-026 m_axis_tready=0; push ranks 30,10,20 -> pop order 10,20,30; tlast=1 on each.
REQ-027 Push rank 7 tdata 0xA then rank 7 tdata 0xB -> outputs 0xA then 0xB.
REQ-028 Push 5 elements -> s_axis_tready=0, 6th beat held; one pop -> s_axis_tready=1 next cycle, 6th accepted.
REQ-029 Queue holds ranks 3,8; same cycle push rank 5 and pop -> 3 popped, then 5, then 8; count 2 after that cycle.
REQ-030 Reset asserted with 4 entries -> count 0, m_axis_tvalid=0 immediately; no stale data after release.
